// File: rtl/apb_gen_pkg.sv
// Shared types and constants for the generic APB4 master: FSM encoding,
// transfer-encoding codes and an elaboration-time clog2 helper.
package apb_gen_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SETUP  = 2'b01,
      S_ACCESS = 2'b10
   } apb_state_e;

   localparam logic [1:0] ENC_WR = 2'b01;
   localparam logic [1:0] ENC_RD = 2'b10;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((32'd1 << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// Selects pready/pslverr/prdata of the addressed slave; every other slave's
// response lines are masked off.
module apb_rsp_mux #(
   parameter int NUM_SLV = 4,
   parameter int DATA_W  = 8,
   parameter int SEL_W   = 2
) (
   input  logic [SEL_W-1:0]          sel_i,
   input  logic [NUM_SLV*DATA_W-1:0] prdata_i,
   input  logic [NUM_SLV-1:0]        pready_i,
   input  logic [NUM_SLV-1:0]        pslverr_i,
   output logic                      pready_o,
   output logic                      pslverr_o,
   output logic [DATA_W-1:0]         prdata_o
);

   // AND-OR select across all slaves
   always_comb begin
      logic hit;
      pready_o  = 1'b0;
      pslverr_o = 1'b0;
      prdata_o  = '0;
      hit       = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         hit       = (32'(sel_i) == i);
         pready_o  = pready_o  | (pready_i[i]  & hit);
         pslverr_o = pslverr_o | (pslverr_i[i] & hit);
         prdata_o  = prdata_o  | (prdata_i[i*DATA_W +: DATA_W] & {DATA_W{hit}});
      end
   end

endmodule

// File: rtl/apb_master_gen.sv
// APB4 master: bridges a valid/ready transfer port onto NUM_SLV slaves with
// per-slave psel decode, access timeout and a registered response channel.
module apb_master_gen
   import apb_gen_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int NUM_SLV     = 4,
   parameter int SEL_W       = 2,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                      pclk_i,
   input  logic                      prst_i,
   input  logic                      trf_valid_i,
   output logic                      trf_ready_o,
   input  logic [1:0]                trf_enc_i,
   input  logic [ADDR_W-1:0]         trf_addr_i,
   input  logic [DATA_W-1:0]         trf_wdata_i,
   input  logic [DATA_W/8-1:0]       trf_strb_i,
   input  logic [2:0]                trf_prot_i,
   output logic                      trf_resp_valid_o,
   output logic [DATA_W-1:0]         trf_rdata_o,
   output logic                      trf_resp_err_o,
   output logic                      trf_resp_timeout_o,
   output logic [NUM_SLV-1:0]        psel_o,
   output logic                      penable_o,
   output logic [ADDR_W-1:0]         paddr_o,
   output logic                      pwrite_o,
   output logic [DATA_W-1:0]         pwdata_o,
   output logic [DATA_W/8-1:0]       pstrb_o,
   output logic [2:0]                pprot_o,
   input  logic [NUM_SLV*DATA_W-1:0] prdata_i,
   input  logic [NUM_SLV-1:0]        pready_i,
   input  logic [NUM_SLV-1:0]        pslverr_i
);

   localparam int STRB_W = DATA_W / 8;
   localparam int TMO_W  = (TIMEOUT_CYC > 0) ? clog2(TIMEOUT_CYC + 1) : 1;

   apb_state_e          state_q,     state_d;
   logic [SEL_W-1:0]    sel_q,       sel_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic                wr_q,        wr_d;
   logic [DATA_W-1:0]   wdata_q,     wdata_d;
   logic [STRB_W-1:0]   strb_q,      strb_d;
   logic [2:0]          prot_q,      prot_d;
   logic [NUM_SLV-1:0]  psel_q,      psel_d;
   logic                penable_q,   penable_d;
   logic [TMO_W-1:0]    tmo_cnt_q,   tmo_cnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q,   rsp_err_d;
   logic                rsp_tmo_q,   rsp_tmo_d;
   logic                err_pend_q,  err_pend_d;

   logic [SEL_W-1:0]    req_sel_s;
   logic                req_enc_ok_s;
   logic                req_launch_s;
   logic                req_acc_s;
   logic                load_s;
   logic                inv_acc_s;
   logic                sel_pready_s;
   logic                sel_pslverr_s;
   logic [DATA_W-1:0]   sel_prdata_s;
   logic                done_s;
   logic                tmo_hit_s;

   apb_rsp_mux #(
      .NUM_SLV (NUM_SLV),
      .DATA_W  (DATA_W),
      .SEL_W   (SEL_W)
   ) u_rsp_mux (
      .sel_i     (sel_q),
      .prdata_i  (prdata_i),
      .pready_i  (pready_i),
      .pslverr_i (pslverr_i),
      .pready_o  (sel_pready_s),
      .pslverr_o (sel_pslverr_s),
      .prdata_o  (sel_prdata_s)
   );

   assign req_sel_s    = trf_addr_i[ADDR_W-1 -: SEL_W];
   assign req_enc_ok_s = (trf_enc_i == ENC_WR) || (trf_enc_i == ENC_RD);
   assign req_launch_s = req_enc_ok_s && (32'(req_sel_s) < NUM_SLV);

   assign done_s    = (state_q == S_ACCESS) && sel_pready_s;
   // Abort fires on the TIMEOUT_CYC-th consecutive not-ready ACCESS cycle.
   assign tmo_hit_s = (TIMEOUT_CYC != 0) && (state_q == S_ACCESS) && !sel_pready_s &&
                      (32'(tmo_cnt_q) >= TIMEOUT_CYC - 1);

   assign trf_ready_o = !prst_i && ((state_q == S_IDLE) || done_s);
   assign req_acc_s   = trf_valid_i && trf_ready_o;
   assign load_s      = req_acc_s && req_launch_s;
   assign inv_acc_s   = req_acc_s && !req_launch_s;

   // FSM next state, request capture and APB output next values
   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = tmo_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (load_s) state_d = S_SETUP;
            else        state_d = S_IDLE;
         end
         S_SETUP: begin
            state_d   = S_ACCESS;
            tmo_cnt_d = '0;
         end
         S_ACCESS: begin
            if (sel_pready_s) begin
               if (load_s) state_d = S_SETUP;
               else        state_d = S_IDLE;
            end else if (tmo_hit_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ACCESS;
               if (32'(tmo_cnt_q) < TIMEOUT_CYC) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               else                              tmo_cnt_d = tmo_cnt_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      sel_d   = load_s ? req_sel_s   : sel_q;
      addr_d  = load_s ? trf_addr_i  : addr_q;
      wr_d    = load_s ? (trf_enc_i == ENC_WR) : wr_q;
      wdata_d = load_s ? trf_wdata_i : wdata_q;
      strb_d  = load_s ? ((trf_enc_i == ENC_WR) ? trf_strb_i : '0) : strb_q;
      prot_d  = load_s ? trf_prot_i  : prot_q;

      psel_d    = (state_d != S_IDLE) ? (NUM_SLV'(1'b1) << sel_d) : '0;
      penable_d = (state_d == S_ACCESS);
   end

   // Response next values; a decode error coinciding with a bus completion is held one cycle
   always_comb begin
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      rsp_tmo_d   = 1'b0;
      err_pend_d  = 1'b0;
      if (done_s) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = sel_pslverr_s;
         rsp_rdata_d = (!wr_q && !sel_pslverr_s) ? sel_prdata_s : '0;
         err_pend_d  = inv_acc_s;
      end else if (tmo_hit_s) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b1;
         rsp_tmo_d   = 1'b1;
      end else if (err_pend_q || inv_acc_s) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b1;
         err_pend_d  = err_pend_q && inv_acc_s;
      end else begin
         rsp_valid_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge pclk_i) begin
      if (prst_i) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         strb_q      <= '0;
         prot_q      <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         tmo_cnt_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_tmo_q   <= 1'b0;
         err_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         strb_q      <= strb_d;
         prot_q      <= prot_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         tmo_cnt_q   <= tmo_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_tmo_q   <= rsp_tmo_d;
         err_pend_q  <= err_pend_d;
      end
   end

   assign psel_o             = psel_q;
   assign penable_o          = penable_q;
   assign paddr_o            = addr_q;
   assign pwrite_o           = wr_q;
   assign pwdata_o           = wdata_q;
   assign pstrb_o            = strb_q;
   assign pprot_o            = prot_q;
   assign trf_resp_valid_o   = rsp_valid_q;
   assign trf_rdata_o        = rsp_rdata_q;
   assign trf_resp_err_o     = rsp_err_q;
   assign trf_resp_timeout_o = rsp_tmo_q;

endmodule
